tick_event_scheduler: RTL

//  Shares the 1 ms game time base among NCH periodic game events (sprite move, enemy step, spawn, blink, ...).

---
 rtl/tick_event_scheduler.sv | 98 +++++++++
 1 files changed

// File: rtl/tick_event_scheduler.sv
// tick_event_scheduler: NCH periodic 1 ms event channels, round-robin serialised onto one valid/ready event port
//   clk_1ms, reset (sync, active-high), pause freezes channel counters
//   cfg_we/cfg_ch/cfg_period/cfg_en: per-channel period and enable write, clears that channel's count and pending flag
//   ev_valid/ev_id/ev_ready: event offer handshake to the game update engine
//   overrun_clr/ev_overrun: sticky per-channel "fired while still pending" flags with per-bit clear
module tick_event_scheduler #(
  parameter int NCH = 4,
  parameter int IDW = 2,
  parameter int CW  = 10
) (
  input  logic           clk_1ms,
  input  logic           reset,
  input  logic           pause,
  input  logic           cfg_we,
  input  logic [IDW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_en,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  input  logic           ev_ready,
  input  logic [NCH-1:0] overrun_clr,
  output logic [NCH-1:0] ev_overrun
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] en_q, en_d, pend_q, pend_d, ovr_q, ovr_d;
  logic [NCH-1:0] wr, active, wrap, fire, deq, cand;
  logic [IDW-1:0] last_q, last_d, id_q, id_d, sel;
  logic           any, hs, load;
  int             idx;
  always_ff @(posedge clk_1ms) begin
    if (reset) begin
      state_q  <= IDLE;
      period_q <= '{default: '0};
      cnt_q    <= '{default: '0};
      en_q     <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      last_q   <= IDW'(NCH - 1);
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      last_q   <= last_d;
      id_q     <= id_d;
    end
  end
  // A channel being rewritten this cycle is neither eligible for selection nor allowed to fire.
  always_comb begin
    cand = '0;
    sel  = '0;
    idx  = 0;
    for (int c = 0; c < NCH; c++) begin
      wr[c]   = cfg_we && cfg_ch == IDW'(c);
      cand[c] = pend_q[c] && !wr[c];
    end
    // Descending scan so the nearest channel after last_q is the final (winning) assignment.
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NCH;
      if (cand[idx]) sel = IDW'(idx);
    end
    any  = |cand;
    hs   = state_q == OFFER && ev_ready;
    load = any && (state_q == IDLE || hs);
    id_d   = load ? sel : id_q;
    last_d = load ? sel : last_q;
  end
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      active[c]   = en_q[c] && period_q[c] != '0 && !pause;
      wrap[c]     = active[c] && cnt_q[c] == period_q[c] - 1'b1;
      fire[c]     = wrap[c] && !wr[c];
      deq[c]      = load && sel == IDW'(c);
      cnt_d[c]    = (wr[c] || wrap[c]) ? '0 : active[c] ? cnt_q[c] + 1'b1 : cnt_q[c];
      period_d[c] = wr[c] ? cfg_period : period_q[c];
      en_d[c]     = wr[c] ? cfg_en : en_q[c];
      pend_d[c]   = !wr[c] && (fire[c] || (pend_q[c] && !deq[c]));
      // A fire landing on the edge that dequeues the same channel is a fresh event, not a merge.
      ovr_d[c]    = (ovr_q[c] && !overrun_clr[c]) || (fire[c] && pend_q[c] && !deq[c]);
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (any ? OFFER : IDLE) : ((hs && !any) ? IDLE : OFFER);
  end
  always_comb begin
    ev_valid   = state_q == OFFER;
    ev_id      = id_q;
    ev_overrun = ovr_q;
  end
endmodule
